tdm_voice_scheduler: RTL and testbench

- Sequences the TDM sample pipeline. Produces the per-slot channel index, channel-enabled flag and key number that feed the voice generators and the pipeline input.
- Owns voice allocation: note-on/note-off requests map to voices, with a round-robin steal when no voice is free.
- Enable-mask changes commit only at frame boundaries. The terminal summer's active-channel count therefore never changes mid-frame.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/voice_free_prio_enc.sv | 24 ++
 rtl/tdm_voice_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_tdm_voice_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM configuration and scheduler FSM encoding.
// Used by tdm_voice_scheduler, voice_free_prio_enc and the sample pipeline.
package tdm_pkg;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned CHANBITS   = 2;
  localparam int unsigned KEY_W      = 7;

  typedef logic [CHANBITS-1:0] chan_t;
  typedef logic [KEY_W-1:0]    key_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ALLOC      = 2'd1,
    WAIT_FRAME = 2'd2
  } sched_state_e;

endpackage

// File: rtl/voice_free_prio_enc.sv
// Lowest-zero-bit priority encoder over the pending voice mask.
// Ports: i_mask (pending enables), o_index (lowest free voice),
//        o_any_free (at least one voice free).
module voice_free_prio_enc
  import tdm_pkg::*;
(
  input  logic [NUM_VOICES-1:0] i_mask,
  output chan_t                 o_index,
  output logic                  o_any_free
);

  // Scan from the top so the lowest free index wins.
  always_comb begin
    o_index    = '0;
    o_any_free = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!i_mask[i]) begin
        o_index    = chan_t'(i);
        o_any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_voice_scheduler.sv
// TDM slot sequencer and voice allocator.
// Ports: dsp_clk/rst (sync, active-high), dsp_enable (slot strobe),
//        note_on_* (valid/ready request), note_off_* (strobe),
//        chan_out/chan_enabled/chan_key/frame_start (per-slot outputs),
//        alloc_valid/alloc_voice/alloc_stolen (allocation report),
//        active_mask (committed enable mask).
module tdm_voice_scheduler
  import tdm_pkg::*;
(
  input  logic                  dsp_clk,
  input  logic                  rst,
  input  logic                  dsp_enable,
  input  logic                  note_on_valid,
  input  logic [KEY_W-1:0]      note_on_key,
  output logic                  note_on_ready,
  input  logic                  note_off_valid,
  input  logic [KEY_W-1:0]      note_off_key,
  output logic [CHANBITS-1:0]   chan_out,
  output logic                  chan_enabled,
  output logic [KEY_W-1:0]      chan_key,
  output logic                  frame_start,
  output logic                  alloc_valid,
  output logic [CHANBITS-1:0]   alloc_voice,
  output logic                  alloc_stolen,
  output logic [NUM_VOICES-1:0] active_mask
);

  sched_state_e          r_state;
  chan_t                 r_slot;
  key_t                  r_key_lat;
  chan_t                 r_steal_ptr;
  logic [NUM_VOICES-1:0] r_pend_en;
  key_t                  r_pend_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_com_en;
  key_t                  r_com_key  [NUM_VOICES];
  logic                  r_ready;
  chan_t                 r_chan_out;
  logic                  r_chan_enabled;
  key_t                  r_chan_key;
  logic                  r_frame_start;
  logic                  r_alloc_valid;
  chan_t                 r_alloc_voice;
  logic                  r_alloc_stolen;

  logic                  w_commit;
  chan_t                 w_slot_next;
  chan_t                 w_free_idx;
  logic                  w_any_free;
  logic                  w_hit;
  chan_t                 w_hit_idx;
  chan_t                 w_alloc_voice;
  logic                  w_alloc_steal;
  logic [NUM_VOICES-1:0] w_pend_en_next;
  key_t                  w_pend_key_next [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_com_en_next;
  key_t                  w_com_key_next  [NUM_VOICES];

  assign w_commit    = dsp_enable && (r_slot == chan_t'(NUM_VOICES - 1));
  assign w_slot_next = w_commit ? '0 : chan_t'(r_slot + chan_t'(1));

  voice_free_prio_enc u_free_enc (
    .i_mask     (r_pend_en),
    .o_index    (w_free_idx),
    .o_any_free (w_any_free)
  );

  // Retrigger lookup: held voice already playing the latched key.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_pend_en[i] && (r_pend_key[i] == r_key_lat)) begin
        w_hit     = 1'b1;
        w_hit_idx = chan_t'(i);
      end
    end
  end

  assign w_alloc_steal = !w_hit && !w_any_free;
  assign w_alloc_voice = w_hit ? w_hit_idx : (w_any_free ? w_free_idx : r_steal_ptr);

  // Pending table update: note-off clears first, allocation write overrides.
  always_comb begin
    w_pend_en_next  = r_pend_en;
    w_pend_key_next = r_pend_key;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (note_off_valid && (r_pend_key[i] == note_off_key)) begin
        w_pend_en_next[i] = 1'b0;
      end
    end
    if (r_state == ALLOC) begin
      w_pend_en_next[w_alloc_voice]  = 1'b1;
      w_pend_key_next[w_alloc_voice] = r_key_lat;
    end
  end

  // Frame-boundary commit sees this cycle's pending writes.
  always_comb begin
    w_com_en_next  = r_com_en;
    w_com_key_next = r_com_key;
    if (w_commit) begin
      w_com_en_next  = w_pend_en_next;
      w_com_key_next = w_pend_key_next;
    end
  end

  // Slot sequencing, tables and allocation FSM.
  always_ff @(posedge dsp_clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_slot         <= chan_t'(NUM_VOICES - 1);
      r_key_lat      <= '0;
      r_steal_ptr    <= '0;
      r_pend_en      <= '0;
      r_com_en       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_pend_key[i] <= '0;
        r_com_key[i]  <= '0;
      end
      r_ready        <= 1'b1;
      r_chan_out     <= '0;
      r_chan_enabled <= 1'b0;
      r_chan_key     <= '0;
      r_frame_start  <= 1'b0;
      r_alloc_valid  <= 1'b0;
      r_alloc_voice  <= '0;
      r_alloc_stolen <= 1'b0;
    end else begin
      r_pend_en      <= w_pend_en_next;
      r_pend_key     <= w_pend_key_next;
      r_com_en       <= w_com_en_next;
      r_com_key      <= w_com_key_next;
      r_frame_start  <= 1'b0;
      r_alloc_valid  <= 1'b0;
      r_alloc_stolen <= 1'b0;

      if (dsp_enable) begin
        r_slot         <= w_slot_next;
        r_chan_out     <= w_slot_next;
        r_chan_enabled <= w_com_en_next[w_slot_next];
        r_chan_key     <= w_com_key_next[w_slot_next];
        r_frame_start  <= w_commit;
      end

      case (r_state)
        IDLE: begin
          if (note_on_valid) begin
            r_key_lat <= note_on_key;
            r_ready   <= 1'b0;
            r_state   <= ALLOC;
          end
        end
        ALLOC: begin
          r_alloc_valid  <= 1'b1;
          r_alloc_voice  <= w_alloc_voice;
          r_alloc_stolen <= w_alloc_steal;
          if (w_alloc_steal) begin
            r_steal_ptr <= (r_steal_ptr == chan_t'(NUM_VOICES - 1)) ?
                           '0 : chan_t'(r_steal_ptr + chan_t'(1));
          end
          r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          // Holding off until the commit caps allocations at one per frame.
          if (w_commit) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign note_on_ready = r_ready;
  assign chan_out      = r_chan_out;
  assign chan_enabled  = r_chan_enabled;
  assign chan_key      = r_chan_key;
  assign frame_start   = r_frame_start;
  assign alloc_valid   = r_alloc_valid;
  assign alloc_voice   = r_alloc_voice;
  assign alloc_stolen  = r_alloc_stolen;
  assign active_mask   = r_com_en;

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// Directed bench for tdm_voice_scheduler: slot sequencing, allocation,
// stealing, retrigger, note-off collision and mid-operation reset.
module tb_tdm_voice_scheduler;
  import tdm_pkg::*;

  logic                  dsp_clk = 1'b0;
  logic                  rst;
  logic                  dsp_enable;
  logic                  note_on_valid;
  logic [KEY_W-1:0]      note_on_key;
  logic                  note_on_ready;
  logic                  note_off_valid;
  logic [KEY_W-1:0]      note_off_key;
  logic [CHANBITS-1:0]   chan_out;
  logic                  chan_enabled;
  logic [KEY_W-1:0]      chan_key;
  logic                  frame_start;
  logic                  alloc_valid;
  logic [CHANBITS-1:0]   alloc_voice;
  logic                  alloc_stolen;
  logic [NUM_VOICES-1:0] active_mask;

  int n_err = 0;
  int n_chk = 0;

  // Expected slot position and committed/pending tables, maintained by hand.
  logic [1:0] slot_m;
  logic [3:0] cur_en, nxt_en;
  logic [6:0] cur_key [4];
  logic [6:0] nxt_key [4];

  always #5 dsp_clk = ~dsp_clk;

  tdm_voice_scheduler dut (
    .dsp_clk        (dsp_clk),
    .rst            (rst),
    .dsp_enable     (dsp_enable),
    .note_on_valid  (note_on_valid),
    .note_on_key    (note_on_key),
    .note_on_ready  (note_on_ready),
    .note_off_valid (note_off_valid),
    .note_off_key   (note_off_key),
    .chan_out       (chan_out),
    .chan_enabled   (chan_enabled),
    .chan_key       (chan_key),
    .frame_start    (frame_start),
    .alloc_valid    (alloc_valid),
    .alloc_voice    (alloc_voice),
    .alloc_stolen   (alloc_stolen),
    .active_mask    (active_mask)
  );

  task automatic step();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    slot_m = 2'd3;
    cur_en = '0;
    nxt_en = '0;
    for (int i = 0; i < 4; i++) begin
      cur_key[i] = '0;
      nxt_key[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
  endtask

  // One slot strobe, then two idle cycles.
  task automatic strobe();
    dsp_enable = 1'b1;
    step();
    dsp_enable = 1'b0;
    slot_m = slot_m + 2'd1;
    if (slot_m == 2'd0) begin
      cur_en  = nxt_en;
      cur_key = nxt_key;
    end
    chk("chan_out", 32'(chan_out), 32'(slot_m));
    chk("frame_start", 32'(frame_start), 32'(slot_m == 2'd0));
    chk("chan_enabled", 32'(chan_enabled), 32'(cur_en[slot_m]));
    chk("chan_key", 32'(chan_key), 32'(cur_key[slot_m]));
    chk("active_mask", 32'(active_mask), 32'(cur_en));
    step();
    chk("frame_start_drop", 32'(frame_start), 32'd0);
    chk("chan_out_hold", 32'(chan_out), 32'(slot_m));
    step();
  endtask

  task automatic run_frame();
    repeat (4) strobe();
  endtask

  task automatic note_on(input logic [6:0] key, input logic [1:0] exp_voice,
                         input logic exp_stolen);
    chk("ready_before", 32'(note_on_ready), 32'd1);
    note_on_valid = 1'b1;
    note_on_key   = key;
    step();
    note_on_valid = 1'b0;
    chk("alloc_valid_early", 32'(alloc_valid), 32'd0);
    chk("ready_accept", 32'(note_on_ready), 32'd0);
    step();
    chk("alloc_valid", 32'(alloc_valid), 32'd1);
    chk("alloc_voice", 32'(alloc_voice), 32'(exp_voice));
    chk("alloc_stolen", 32'(alloc_stolen), 32'(exp_stolen));
    chk("mask_not_yet", 32'(active_mask), 32'(cur_en));
    step();
    chk("alloc_valid_drop", 32'(alloc_valid), 32'd0);
    chk("ready_wait", 32'(note_on_ready), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    dsp_enable     = 1'b0;
    note_on_valid  = 1'b0;
    note_on_key    = '0;
    note_off_valid = 1'b0;
    note_off_key   = '0;
    clear_model();

    // Reset state
    step();
    step();
    chk("rst_chan_out", 32'(chan_out), 32'd0);
    chk("rst_chan_enabled", 32'(chan_enabled), 32'd0);
    chk("rst_chan_key", 32'(chan_key), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("rst_alloc_voice", 32'(alloc_voice), 32'd0);
    chk("rst_alloc_stolen", 32'(alloc_stolen), 32'd0);
    chk("rst_active_mask", 32'(active_mask), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(note_on_ready), 32'd1);

    // Eight strobes: 0,1,2,3,0,1,2,3 with frame_start after strobes 1 and 5
    repeat (8) strobe();
    chk("idle_ready", 32'(note_on_ready), 32'd1);

    // Note-on key 60 mid-frame (slot 1)
    strobe();
    strobe();
    note_on(7'd60, 2'd0, 1'b0);
    nxt_en[0] = 1'b1; nxt_key[0] = 7'd60;
    strobe();
    strobe();
    strobe();
    chk("mask_60", 32'(active_mask), 32'h1);
    chk("ready_after_commit", 32'(note_on_ready), 32'd1);

    // Fill voices 1..3, then steal voice 0
    note_on(7'd62, 2'd1, 1'b0);
    nxt_en[1] = 1'b1; nxt_key[1] = 7'd62;
    run_frame();
    note_on(7'd64, 2'd2, 1'b0);
    nxt_en[2] = 1'b1; nxt_key[2] = 7'd64;
    run_frame();
    note_on(7'd65, 2'd3, 1'b0);
    nxt_en[3] = 1'b1; nxt_key[3] = 7'd65;
    run_frame();
    note_on(7'd67, 2'd0, 1'b1);
    nxt_key[0] = 7'd67;
    run_frame();

    // Retrigger of held key 62 reuses voice 1
    note_on(7'd62, 2'd1, 1'b0);
    run_frame();
    chk("mask_full", 32'(active_mask), 32'hF);

    // Steal pointer advanced to 1
    note_on(7'd71, 2'd1, 1'b1);
    nxt_key[1] = 7'd71;
    run_frame();

    // Note-off 62 collides with ALLOC of key 70
    do_reset();
    strobe();
    note_on(7'd60, 2'd0, 1'b0);
    nxt_en[0] = 1'b1; nxt_key[0] = 7'd60;
    run_frame();
    note_on(7'd62, 2'd1, 1'b0);
    nxt_en[1] = 1'b1; nxt_key[1] = 7'd62;
    run_frame();
    chk("ready_70", 32'(note_on_ready), 32'd1);
    note_on_valid = 1'b1;
    note_on_key   = 7'd70;
    step();
    note_on_valid  = 1'b0;
    note_off_valid = 1'b1;
    note_off_key   = 7'd62;
    step();
    note_off_valid = 1'b0;
    chk("coll_alloc_valid", 32'(alloc_valid), 32'd1);
    chk("coll_alloc_voice", 32'(alloc_voice), 32'd2);
    chk("coll_alloc_stolen", 32'(alloc_stolen), 32'd0);
    step();
    nxt_en[1] = 1'b0;
    nxt_en[2] = 1'b1; nxt_key[2] = 7'd70;
    run_frame();
    run_frame();
    chk("coll_mask", 32'(active_mask), 32'h5);

    // Note-off for a key not held
    note_off_valid = 1'b1;
    note_off_key   = 7'd99;
    step();
    note_off_valid = 1'b0;
    run_frame();

    // Reset while in WAIT_FRAME
    strobe();
    note_on_valid = 1'b1;
    note_on_key   = 7'd64;
    step();
    note_on_valid = 1'b0;
    step();
    chk("pre_rst_alloc_voice", 32'(alloc_voice), 32'd1);
    chk("pre_rst_ready", 32'(note_on_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    chk("mid_rst_ready", 32'(note_on_ready), 32'd1);
    chk("mid_rst_mask", 32'(active_mask), 32'd0);
    chk("mid_rst_chan_out", 32'(chan_out), 32'd0);
    chk("mid_rst_alloc_valid", 32'(alloc_valid), 32'd0);
    strobe();
    strobe();
    run_frame();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
